// File: rtl/parking_pkg.sv
// Shared exit-lane definitions: fee FSM state encoding, bill values and
// the default tariff constants also used by the ticket FSM.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DUE  = 2'd2,
        PAID = 2'd3
    } fee_state_t;

    localparam int unsigned BILL2_VAL         = 2;
    localparam int unsigned BILL4_VAL         = 4;

    localparam int unsigned DEF_MIN_PER_HOUR  = 60;
    localparam int unsigned DEF_FREE_MIN      = 15;
    localparam int unsigned DEF_RATE_PER_HOUR = 2;
    localparam int unsigned DEF_MAX_FEE       = 98;

endpackage

// File: rtl/bin7_to_bcd2.sv
// Combinational 7-bit binary to two-digit BCD {tens, ones}; inputs 0..99.
module bin7_to_bcd2 (
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [3:0] ones;

    always_comb begin
        tens = 4'(bin / 7'd10);
        ones = 4'(bin % 7'd10);
        bcd  = {tens, ones};
    end

endmodule

// File: rtl/exit_fee_unit.sv
// Exit-lane fee unit: computes the parking fee by repeated hour subtraction,
// collects $2/$4 bills, drives the BCD displays and pulses paid when settled.
module exit_fee_unit
    import parking_pkg::*;
#(
    parameter int unsigned DWIDTH        = 16,
    parameter int unsigned MIN_PER_HOUR  = DEF_MIN_PER_HOUR,
    parameter int unsigned FREE_MIN      = DEF_FREE_MIN,
    parameter int unsigned RATE_PER_HOUR = DEF_RATE_PER_HOUR,
    parameter int unsigned MAX_FEE       = DEF_MAX_FEE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              calc_start,
    input  logic [DWIDTH-1:0] parking_time_min,
    input  logic              bill_2,
    input  logic              bill_4,
    input  logic              cancel,
    output logic              busy,
    output logic              fee_valid,
    output logic [7:0]        fee_bcd,
    output logic              paid,
    output logic [7:0]        overpay_bcd
);

    localparam logic [6:0]        MAX_FEE_W = 7'(MAX_FEE);
    localparam logic [6:0]        RATE_W    = 7'(RATE_PER_HOUR);
    localparam logic [DWIDTH-1:0] MPH_W     = DWIDTH'(MIN_PER_HOUR);
    localparam logic [DWIDTH-1:0] FREE_W    = DWIDTH'(FREE_MIN);

    fee_state_t        state, state_nxt;
    logic [6:0]        fee_acc, fee_acc_nxt;
    logic [6:0]        remaining, remaining_nxt;
    logic [DWIDTH-1:0] mins_left, mins_left_nxt;
    logic [2:0]        overpay, overpay_nxt;
    logic [2:0]        bill_val;
    logic [7:0]        fee_sum;

    assign bill_val = (bill_2 ? 3'(BILL2_VAL) : 3'd0) + (bill_4 ? 3'(BILL4_VAL) : 3'd0);
    // One bit wider so the saturation compare sees any carry past 7 bits
    assign fee_sum  = {1'b0, fee_acc} + {1'b0, RATE_W};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            fee_acc   <= '0;
            remaining <= '0;
            mins_left <= '0;
            overpay   <= '0;
        end else begin
            state     <= state_nxt;
            fee_acc   <= fee_acc_nxt;
            remaining <= remaining_nxt;
            mins_left <= mins_left_nxt;
            overpay   <= overpay_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fee_acc_nxt   = fee_acc;
        remaining_nxt = remaining;
        mins_left_nxt = mins_left;
        overpay_nxt   = overpay;

        if (cancel) begin
            state_nxt     = IDLE;
            fee_acc_nxt   = '0;
            remaining_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (calc_start) begin
                        state_nxt     = CALC;
                        fee_acc_nxt   = '0;
                        overpay_nxt   = '0;
                        mins_left_nxt = (parking_time_min <= FREE_W) ? '0 : parking_time_min;
                    end
                end
                CALC: begin
                    if (mins_left == '0 || fee_acc == MAX_FEE_W) begin
                        remaining_nxt = fee_acc;
                        state_nxt     = (fee_acc != '0) ? DUE : PAID;
                    end else begin
                        fee_acc_nxt   = (fee_sum > {1'b0, MAX_FEE_W}) ? MAX_FEE_W : fee_sum[6:0];
                        mins_left_nxt = (mins_left > MPH_W) ? mins_left - MPH_W : '0;
                    end
                end
                DUE: begin
                    if ({4'b0, bill_val} >= remaining) begin
                        // remaining is 1..6 here, so the credit always fits 3 bits
                        overpay_nxt   = 3'({4'b0, bill_val} - remaining);
                        remaining_nxt = '0;
                        state_nxt     = PAID;
                    end else begin
                        remaining_nxt = remaining - {4'b0, bill_val};
                    end
                end
                PAID: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign fee_valid = (state == DUE);
    assign paid      = (state == PAID);

    bin7_to_bcd2 u_fee_bcd (
        .bin (remaining),
        .bcd (fee_bcd)
    );

    bin7_to_bcd2 u_overpay_bcd (
        .bin ({4'b0, overpay}),
        .bcd (overpay_bcd)
    );

endmodule

// File: tb/tb_exit_fee_unit.sv
// Directed bench for exit_fee_unit: expected outputs are queued when stimulus
// is driven and compared when the DUT responds.
module tb_exit_fee_unit;

    logic        clk;
    logic        reset_n;
    logic        calc_start;
    logic [15:0] parking_time_min;
    logic        bill_2;
    logic        bill_4;
    logic        cancel;
    logic        busy;
    logic        fee_valid;
    logic [7:0]  fee_bcd;
    logic        paid;
    logic [7:0]  overpay_bcd;

    exit_fee_unit #(
        .DWIDTH        (16),
        .MIN_PER_HOUR  (60),
        .FREE_MIN      (15),
        .RATE_PER_HOUR (2),
        .MAX_FEE       (98)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .calc_start       (calc_start),
        .parking_time_min (parking_time_min),
        .bill_2           (bill_2),
        .bill_4           (bill_4),
        .cancel           (cancel),
        .busy             (busy),
        .fee_valid        (fee_valid),
        .fee_bcd          (fee_bcd),
        .paid             (paid),
        .overpay_bcd      (overpay_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       fv;
        logic       pd;
        logic       bz;
        logic [7:0] fb;
        logic [7:0] ob;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    m_rem    = 0;
    int    m_over   = 0;
    int    exp_lat  = 0;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    // Independent closed form: started hours beyond the grace period, capped.
    function automatic int model_hours(input int mins);
        int h;
        if (mins <= 15) return 0;
        h = (mins + 59) / 60;
        if (h > 49) h = 49;
        return h;
    endfunction

    function automatic int model_fee(input int mins);
        int f;
        f = 2 * model_hours(mins);
        return (f > 98) ? 98 : f;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic fv, input logic pd, input logic bz,
                        input logic [7:0] fb, input logic [7:0] ob);
        exp_t e;
        e.fv = fv; e.pd = pd; e.bz = bz; e.fb = fb; e.ob = ob;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic push_idle(input string tag);
        push(tag, 1'b0, 1'b0, 1'b0, 8'h00, to_bcd(m_over));
    endtask

    task automatic observe();
        exp_t  e;
        string t;
        cmp("scoreboard_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        cmp({t, ".fee_valid"},   32'(fee_valid),   32'(e.fv));
        cmp({t, ".paid"},        32'(paid),        32'(e.pd));
        cmp({t, ".busy"},        32'(busy),        32'(e.bz));
        cmp({t, ".fee_bcd"},     32'(fee_bcd),     32'(e.fb));
        cmp({t, ".overpay_bcd"}, 32'(overpay_bcd), 32'(e.ob));
    endtask

    // Drives one cycle of inputs; the expectation must already be queued.
    task automatic drive(input logic b2, input logic b4, input logic cs,
                         input logic cn, input int mins);
        bill_2 = b2; bill_4 = b4; calc_start = cs; cancel = cn;
        parking_time_min = 16'(mins);
        tick();
        bill_2 = 1'b0; bill_4 = 1'b0; calc_start = 1'b0; cancel = 1'b0;
        observe();
    endtask

    task automatic idle_step(input string tag, input logic b2, input logic b4);
        push_idle(tag);
        drive(b2, b4, 1'b0, 1'b0, 0);
    endtask

    task automatic start_calc(input int mins);
        parking_time_min = 16'(mins);
        calc_start = 1'b1;
        tick();
        calc_start = 1'b0;
    endtask

    task automatic run_calc(input string tag, input int mins);
        int fee;
        int n;
        fee     = model_fee(mins);
        exp_lat = model_hours(mins) + 1;
        m_rem   = fee;
        m_over  = 0;
        start_calc(mins);
        if (fee != 0) push(tag, 1'b1, 1'b0, 1'b1, to_bcd(fee), 8'h00);
        else          push(tag, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(fee_valid || paid) && n < 60);
        cmp({tag, ".latency"}, 32'(n), 32'(exp_lat));
        observe();
    endtask

    task automatic pay(input string tag, input logic b2, input logic b4);
        int bv;
        bv = (b2 ? 2 : 0) + (b4 ? 4 : 0);
        if (bv >= m_rem) begin
            m_over = bv - m_rem;
            m_rem  = 0;
            push(tag, 1'b0, 1'b1, 1'b1, 8'h00, to_bcd(m_over));
        end else begin
            m_rem = m_rem - bv;
            push(tag, 1'b1, 1'b0, 1'b1, to_bcd(m_rem), to_bcd(m_over));
        end
        drive(b2, b4, 1'b0, 1'b0, 0);
    endtask

    task automatic cancel_step(input string tag, input logic b2, input logic b4,
                               input logic cs, input int mins);
        m_rem = 0;
        push_idle(tag);
        drive(b2, b4, cs, 1'b1, mins);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1;
        calc_start = 1'b0; bill_2 = 1'b0; bill_4 = 1'b0; cancel = 1'b0;
        parking_time_min = '0;
        #1 reset_n = 1'b0;
        #1;
        push_idle("reset");
        observe();
        tick();
        tick();
        reset_n = 1'b1;
        idle_step("after_reset", 1'b0, 1'b0);

        // 61 min: two started hours, $4, paid with an exact $4 bill
        run_calc("calc61", 61);
        pay("calc61_bill4", 1'b0, 1'b1);
        idle_step("calc61_idle", 1'b0, 1'b0);

        // Inside grace period: no fee, straight to paid
        run_calc("calc10", 10);
        idle_step("calc10_idle", 1'b0, 1'b0);

        // Saturates at the cap
        run_calc("calc3000", 3000);
        cancel_step("calc3000_cancel", 1'b0, 1'b0, 1'b0, 0);

        // Both bills in one cycle overpay by $2; credit holds in IDLE
        run_calc("calc120a", 120);
        pay("calc120a_both", 1'b1, 1'b1);
        idle_step("calc120a_idle", 1'b0, 1'b0);
        idle_step("calc120a_hold", 1'b1, 1'b0);

        // Two $2 bills step the display down; new calc clears the credit
        run_calc("calc120b", 120);
        pay("calc120b_first", 1'b1, 1'b0);
        pay("calc120b_second", 1'b1, 1'b0);
        idle_step("calc120b_idle", 1'b0, 1'b0);

        // Cancel during CALC
        start_calc(400);
        tick();
        cancel_step("calc400_cancel", 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) idle_step("calc400_quiet", 1'b0, 1'b0);

        // DUE: calc_start ignored, cancel beats a bill, later bills ignored
        run_calc("calc120c", 120);
        push("due_calc_ignored", 1'b1, 1'b0, 1'b1, to_bcd(m_rem), to_bcd(m_over));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3000);
        cancel_step("due_cancel_bill", 1'b0, 1'b1, 1'b0, 0);
        idle_step("due_after_cancel_b4", 1'b0, 1'b1);
        idle_step("due_after_cancel_b2", 1'b1, 1'b0);

        // Asynchronous reset in DUE (fee 6, $2 paid)
        run_calc("calc150", 150);
        pay("calc150_bill2", 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        m_rem = 0;
        m_over = 0;
        push_idle("mid_due_reset");
        observe();
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle_step("post_reset_b2", 1'b1, 1'b0);
        idle_step("post_reset_b4", 1'b0, 1'b1);
        idle_step("post_reset_quiet", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
